// File: rtl/insn_encode.sv
// RV32I instruction encoder: packs decoded fields into 32-bit words, tags each with
// a sequential word address and buffers them in a 2-entry registered FIFO.
module insn_encode #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    opcode,
    input  logic [3:0]    alu_op,
    input  logic [4:0]    rd,
    input  logic [4:0]    rs1,
    input  logic [4:0]    rs2,
    input  logic [31:0]   imm,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_insn,
    output logic [AW-1:0] out_addr,
    output logic          err,
    output logic [7:0]    err_cnt
);

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    logic [2:0]    funct3;
    logic [6:0]    funct7;
    logic [31:0]   word;
    logic          drop;
    logic          accept;
    logic          push;
    logic          pop;

    logic [31:0]   mem_insn [2];
    logic [AW-1:0] mem_addr [2];
    logic          rd_ptr;
    logic          wr_ptr;
    logic [1:0]    count;
    logic [AW-1:0] addr_cnt;

    assign funct3 = alu_op[2:0];
    assign funct7 = {1'b0, alu_op[3], 5'b00000};

    always_comb begin
        word = '0;
        drop = 1'b0;
        case (opcode)
            OPC_OP: word = {funct7, rs2, rs1, funct3, rd, opcode, 2'b11};
            OPC_OP_IMM: begin
                // Shift-immediates carry funct7 in the upper bits, only shamt in [24:20]
                if (funct3 == 3'b001 || funct3 == 3'b101)
                    word = {funct7, imm[4:0], rs1, funct3, rd, opcode, 2'b11};
                else
                    word = {imm[11:0], rs1, funct3, rd, opcode, 2'b11};
            end
            OPC_LOAD: word = {imm[11:0], rs1, funct3, rd, opcode, 2'b11};
            OPC_JALR: begin
                word = {imm[11:0], rs1, funct3, rd, opcode, 2'b11};
                drop = (funct3 != 3'b000);
            end
            OPC_STORE: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode, 2'b11};
            OPC_BRANCH: begin
                word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode, 2'b11};
                drop = imm[0];
            end
            OPC_LUI, OPC_AUIPC: word = {imm[31:12], rd, opcode, 2'b11};
            OPC_JAL: begin
                word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode, 2'b11};
                drop = imm[0];
            end
            default: drop = 1'b1;
        endcase
    end

    // in_ready depends only on the registered count, never on out_ready
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_insn  = mem_insn[rd_ptr];
    assign out_addr  = mem_addr[rd_ptr];

    assign accept = in_valid && in_ready;
    assign push   = accept && !drop;
    assign pop    = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_insn[0] <= '0;
            mem_insn[1] <= '0;
            mem_addr[0] <= '0;
            mem_addr[1] <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count       <= 2'd0;
            addr_cnt    <= '0;
            err         <= 1'b0;
            err_cnt     <= 8'd0;
        end else begin
            if (push) begin
                mem_insn[wr_ptr] <= word;
                mem_addr[wr_ptr] <= addr_cnt;
                wr_ptr           <= ~wr_ptr;
                addr_cnt         <= addr_cnt + 1'b1;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            // Dropped sets still complete the handshake but leave no trace in the FIFO
            if (accept && drop) begin
                err <= 1'b1;
                if (err_cnt != 8'hFF)
                    err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_insn_encode.sv
// Self-checking bench for insn_encode: vector table, corner-case sequences and
// randomized traffic compared against a queue-based reference model.
module tb_insn_encode;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    opcode;
    logic [3:0]    alu_op;
    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [31:0]   imm;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_insn;
    logic [AW-1:0] out_addr;
    logic          err;
    logic [7:0]    err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] insn;
        int          addr;
    } entry_t;

    entry_t q[$];
    int     m_addr   = 0;
    bit     m_err    = 0;
    int     m_errcnt = 0;
    bit     known    = 0;

    typedef struct {
        logic [4:0]  opc;
        logic [3:0]  aop;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp_insn;
        bit          exp_drop;
    } vec_t;

    insn_encode #(.AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .alu_op    (alu_op),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_insn  (out_insn),
        .out_addr  (out_addr),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    // Reference encoder built from field positions with plain shift-and-add arithmetic
    function automatic void ref_encode(input logic [4:0] o, input logic [3:0] a,
                                       input logic [4:0] d, input logic [4:0] s1,
                                       input logic [4:0] s2, input logic [31:0] im,
                                       output logic [31:0] w, output bit dr);
        logic [31:0] f3, f7, base, iimm;
        f3   = 32'(a) & 32'd7;
        f7   = a[3] ? 32'd32 : 32'd0;
        base = 32'd3 + (32'(o) << 2);
        iimm = (im & 32'hFFF) << 20;
        w  = 32'd0;
        dr = 0;
        case (o)
            5'b01100: w = base + (32'(d) << 7) + (f3 << 12) + (32'(s1) << 15) + (32'(s2) << 20) + (f7 << 25);
            5'b00100: begin
                if (f3 == 1 || f3 == 5)
                    w = base + (32'(d) << 7) + (f3 << 12) + (32'(s1) << 15) + ((im & 32'd31) << 20) + (f7 << 25);
                else
                    w = base + (32'(d) << 7) + (f3 << 12) + (32'(s1) << 15) + iimm;
            end
            5'b00000: w = base + (32'(d) << 7) + (f3 << 12) + (32'(s1) << 15) + iimm;
            5'b11001: begin
                w  = base + (32'(d) << 7) + (f3 << 12) + (32'(s1) << 15) + iimm;
                dr = (f3 != 0);
            end
            5'b01000: w = base + ((im & 32'd31) << 7) + (f3 << 12) + (32'(s1) << 15) + (32'(s2) << 20)
                          + (((im >> 5) & 32'h7F) << 25);
            5'b11000: begin
                w = base + (((im >> 11) & 1) << 7) + (((im >> 1) & 15) << 8) + (f3 << 12) + (32'(s1) << 15)
                    + (32'(s2) << 20) + (((im >> 5) & 63) << 25) + (((im >> 12) & 1) << 31);
                dr = im[0];
            end
            5'b01101, 5'b00101: w = base + (32'(d) << 7) + (im & 32'hFFFFF000);
            5'b11011: begin
                w = base + (32'(d) << 7) + (((im >> 12) & 255) << 12) + (((im >> 11) & 1) << 20)
                    + (((im >> 1) & 1023) << 21) + (((im >> 20) & 1) << 31);
                dr = im[0];
            end
            default: dr = 1;
        endcase
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        in_valid = 1'b1;
        opcode   = v.opc;
        alu_op   = v.aop;
        rd       = v.rd;
        rs1      = v.rs1;
        rs2      = v.rs2;
        imm      = v.imm;
    endtask

    // Called at a falling edge: compare outputs to the model, advance one clock, update the model
    task automatic cycle();
        bit          acc, pp, dr;
        logic [31:0] w;
        entry_t      e;
        if (known) begin
            check_output("in_ready", 32'(in_ready), 32'(q.size() < 2));
            check_output("out_valid", 32'(out_valid), 32'(q.size() > 0));
            if (q.size() > 0) begin
                check_output("out_insn", out_insn, q[0].insn);
                check_output("out_addr", 32'(out_addr), 32'(q[0].addr));
            end
            check_output("err", 32'(err), 32'(m_err));
            check_output("err_cnt", 32'(err_cnt), 32'(m_errcnt));
        end
        acc = in_valid && (q.size() < 2);
        pp  = out_ready && (q.size() > 0);
        ref_encode(opcode, alu_op, rd, rs1, rs2, imm, w, dr);
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_addr   = 0;
            m_err    = 0;
            m_errcnt = 0;
            known    = 1;
        end else begin
            if (pp) void'(q.pop_front());
            if (acc) begin
                if (dr) begin
                    m_err = 1;
                    if (m_errcnt < 255) m_errcnt++;
                end else begin
                    e.insn = w;
                    e.addr = m_addr;
                    q.push_back(e);
                    m_addr = (m_addr + 1) % (1 << AW);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    vec_t vecs[14];
    vec_t v;
    int   wrap_exp[5];
    logic [4:0] pool[10];

    initial begin
        vecs[0]  = '{5'b01100, 4'b0000, 5'd1, 5'd2, 5'd3, 32'd0,          32'h003100B3, 0};
        vecs[1]  = '{5'b01100, 4'b1000, 5'd1, 5'd2, 5'd3, 32'd0,          32'h403100B3, 0};
        vecs[2]  = '{5'b00100, 4'b0000, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF,   32'hFFF00293, 0};
        vecs[3]  = '{5'b00100, 4'b1101, 5'd1, 5'd1, 5'd0, 32'd3,          32'h4030D093, 0};
        vecs[4]  = '{5'b11000, 4'b0000, 5'd0, 5'd1, 5'd2, 32'd8,          32'h00208463, 0};
        vecs[5]  = '{5'b11011, 4'b0000, 5'd1, 5'd0, 5'd0, 32'd8,          32'h008000EF, 0};
        vecs[6]  = '{5'b01000, 4'b0010, 5'd0, 5'd1, 5'd2, 32'd4,          32'h0020A223, 0};
        vecs[7]  = '{5'b01101, 4'b0000, 5'd3, 5'd0, 5'd0, 32'h12345000,   32'h123451B7, 0};
        vecs[8]  = '{5'b00101, 4'b0000, 5'd0, 5'd0, 5'd0, 32'hABCDE123,   32'hABCDE017, 0};
        vecs[9]  = '{5'b00000, 4'b0010, 5'd5, 5'd2, 5'd0, 32'hFFFFFFFC,   32'hFFC12283, 0};
        vecs[10] = '{5'b11001, 4'b0000, 5'd1, 5'd5, 5'd0, 32'd0,          32'h000280E7, 0};
        vecs[11] = '{5'b11000, 4'b0001, 5'd0, 5'd1, 5'd0, 32'hFFFFFFFC,   32'hFE009EE3, 0};
        vecs[12] = '{5'b11001, 4'b0001, 5'd1, 5'd5, 5'd0, 32'd0,          32'h0,        1};
        vecs[13] = '{5'b11000, 4'b0000, 5'd0, 5'd1, 5'd2, 32'd9,          32'h0,        1};
        wrap_exp = '{0, 1, 2, 3, 0};
        pool = '{5'b01100, 5'b00100, 5'b00000, 5'b11001, 5'b01000,
                 5'b11000, 5'b01101, 5'b00101, 5'b11011, 5'b11100};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        opcode = '0; alu_op = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        @(negedge clk);
        do_reset();
        check_output("rst_insn", out_insn, 32'h0);
        check_output("rst_addr", 32'(out_addr), 32'h0);

        // Vector table, one set at a time with an always-ready consumer
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i]);
            cycle();
            in_valid = 1'b0;
            check_output($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(!vecs[i].exp_drop));
            if (!vecs[i].exp_drop)
                check_output($sformatf("tbl%0d_insn", i), out_insn, vecs[i].exp_insn);
            cycle();
        end

        // Drops: nothing emitted, errors counted, address not consumed
        do_reset();
        v = '{5'b11011, 4'b0000, 5'd1, 5'd0, 5'd0, 32'd7, 32'h0, 1};
        apply_stimulus(v);
        cycle();
        v.opc = 5'b11100;
        apply_stimulus(v);
        cycle();
        in_valid = 1'b0;
        check_output("drop_valid", 32'(out_valid), 32'd0);
        check_output("drop_err", 32'(err), 32'd1);
        check_output("drop_cnt", 32'(err_cnt), 32'd2);
        apply_stimulus(vecs[2]);
        cycle();
        in_valid = 1'b0;
        check_output("drop_next_addr", 32'(out_addr), 32'd0);
        check_output("drop_next_insn", out_insn, 32'hFFF00293);
        cycle();

        // Backpressure: third set refused, in_ready returns one cycle after the first pop
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            v = vecs[0];
            v.rd = 5'(i + 7);
            apply_stimulus(v);
            cycle();
        end
        in_valid = 1'b0;
        check_output("bp_full", 32'(in_ready), 32'd0);
        check_output("bp_head_addr", 32'(out_addr), 32'd0);
        out_ready = 1'b1;
        check_output("bp_no_comb", 32'(in_ready), 32'd0);
        cycle();
        check_output("bp_ready_back", 32'(in_ready), 32'd1);
        check_output("bp_second_addr", 32'(out_addr), 32'd1);
        cycle();
        cycle();

        // Address wrap at AW=2 under full throughput
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i < 5) begin
                v = vecs[7];
                v.rd = 5'(i);
                apply_stimulus(v);
            end else begin
                in_valid = 1'b0;
            end
            cycle();
            if (i < 5)
                check_output($sformatf("wrap%0d", i), 32'(out_addr), 32'(wrap_exp[i]));
        end

        // Reset while full and with error state set
        do_reset();
        out_ready = 1'b0;
        apply_stimulus(vecs[12]);
        cycle();
        apply_stimulus(vecs[0]);
        cycle();
        cycle();
        check_output("pre_rst_err", 32'(err), 32'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        in_valid = 1'b0;
        check_output("post_rst_valid", 32'(out_valid), 32'd0);
        check_output("post_rst_err", 32'(err), 32'd0);
        check_output("post_rst_cnt", 32'(err_cnt), 32'd0);
        out_ready = 1'b1;
        apply_stimulus(vecs[1]);
        cycle();
        in_valid = 1'b0;
        check_output("post_rst_addr", 32'(out_addr), 32'd0);
        cycle();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(63) == 0);
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            opcode    = ($urandom_range(7) == 0) ? 5'($urandom) : pool[$urandom_range(9)];
            alu_op    = 4'($urandom);
            rd        = 5'($urandom);
            rs1       = 5'($urandom);
            rs2       = 5'($urandom);
            imm       = $urandom;
            if ($urandom_range(3) != 0) imm[0] = 1'b0;
            if ((opcode == 5'b11001) && ($urandom_range(3) != 0)) alu_op[2:0] = 3'b000;
            cycle();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        cycle();
        cycle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
